// File: rtl/scan_access_arbiter.sv
// Round-robin arbiter sharing one scan_controller between NUM_REQ host requesters.
// Optional watchdog on the ready-strobe waits: define SCAN_ARB_TIMEOUT_EN.
module scan_access_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_DESIGNS = 4,
    parameter int NUM_IOS     = 8,
    parameter int SEL_W       = 9,
    parameter int TIMEOUT     = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SEL_W-1:0]   req_select,
    input  logic [NUM_REQ*NUM_IOS-1:0] req_inputs,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       resp_valid,
    output logic [NUM_IOS-1:0]         resp_outputs,
    output logic                       resp_error,
    output logic [SEL_W-1:0]           ctrl_active_select,
    output logic [NUM_IOS-1:0]         ctrl_inputs,
    input  logic [NUM_IOS-1:0]         ctrl_outputs,
    input  logic                       ctrl_ready
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_chk
        $error("scan_access_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, SWITCH, FLUSH_B, FLUSH_D, RUN_B, RUN_D, CAPTURE
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [PTR_W-1:0]     rr_q;
    logic [SEL_W-1:0]     sel_q, csel_q;
    logic [NUM_IOS-1:0]   in_q, cin_q, resp_out_q;
    logic                 resp_valid_q, resp_error_q;

    logic [SEL_W-1:0]     sel_arr [NUM_REQ];
    logic [NUM_IOS-1:0]   in_arr  [NUM_REQ];
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W:0]       idx;
    logic                 adv, waiting, timeout_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign sel_arr[i] = req_select[i*SEL_W +: SEL_W];
        assign in_arr[i]  = req_inputs[i*NUM_IOS +: NUM_IOS];
    end

    // Search starts at the rr pointer and wraps, so the last winner ranks last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!win_found && req[idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // adv: the condition that moves a waiting state forward on this edge.
    always_comb begin
        adv = 1'b0;
        case (state_q)
            SWITCH, FLUSH_D, RUN_D: adv = ctrl_ready;
            FLUSH_B, RUN_B:         adv = !ctrl_ready;
            default:                adv = 1'b0;
        endcase
    end
    assign waiting = (state_q != IDLE) && (state_q != CAPTURE);

`ifdef SCAN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt_q <= '0;
        else if (!waiting || adv) cnt_q <= '0;
        else                      cnt_q <= cnt_q + 1'b1;
    end
    assign timeout_hit = waiting && !adv && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            sel_q        <= '0;
            in_q         <= '0;
            csel_q       <= '0;
            cin_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_out_q   <= '0;
        end else if (timeout_hit) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_out_q   <= '0;
            state_q      <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // The response cycle itself never arbitrates, so a requester that
                    // drops req on seeing its response is not granted again.
                    if (resp_valid_q) begin
                        resp_valid_q <= 1'b0;
                        resp_error_q <= 1'b0;
                        grant_q      <= '0;
                    end else if (win_found) begin
                        grant_q <= NUM_REQ'(1) << win_idx;
                        rr_q    <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        sel_q   <= sel_arr[win_idx];
                        in_q    <= in_arr[win_idx];
                        state_q <= (sel_arr[win_idx] >= SEL_W'(NUM_DESIGNS)) ? CAPTURE : SWITCH;
                    end
                end
                SWITCH: if (adv) begin
                    csel_q  <= sel_q;
                    cin_q   <= in_q;
                    state_q <= FLUSH_B;
                end
                FLUSH_B: if (adv) state_q <= FLUSH_D;
                FLUSH_D: if (adv) state_q <= RUN_B;
                RUN_B:   if (adv) state_q <= RUN_D;
                RUN_D:   if (adv) state_q <= CAPTURE;
                CAPTURE: begin
                    resp_valid_q <= 1'b1;
                    if (sel_q >= SEL_W'(NUM_DESIGNS)) begin
                        resp_error_q <= 1'b1;
                        resp_out_q   <= '0;
                    end else begin
                        resp_error_q <= 1'b0;
                        resp_out_q   <= ctrl_outputs;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant              = grant_q;
    assign resp_valid         = resp_valid_q;
    assign resp_outputs       = resp_out_q;
    assign resp_error         = resp_error_q;
    assign ctrl_active_select = csel_q;
    assign ctrl_inputs        = cin_q;
endmodule

// File: tb/tb_scan_access_arbiter.sv
// Bench for scan_access_arbiter: behavioural scan_controller model plus response scoreboard.
`timescale 1ns/1ps
module tb_scan_access_arbiter;
    localparam int NR = 4, ND = 4, NI = 8, SW = 9;
    localparam int ROUND = 4*ND*NI + 3;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req;
    logic [NR*SW-1:0] req_select;
    logic [NR*NI-1:0] req_inputs;
    logic [NR-1:0]    grant;
    logic             resp_valid, resp_error;
    logic [NI-1:0]    resp_outputs;
    logic [SW-1:0]    ctrl_active_select;
    logic [NI-1:0]    ctrl_inputs;
    logic [NI-1:0]    ctrl_outputs = '0;
    logic             ctrl_ready = 1'b0;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    scan_access_arbiter #(.NUM_REQ(NR), .NUM_DESIGNS(ND), .NUM_IOS(NI), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_select(req_select), .req_inputs(req_inputs),
        .grant(grant), .resp_valid(resp_valid), .resp_outputs(resp_outputs), .resp_error(resp_error),
        .ctrl_active_select(ctrl_active_select), .ctrl_inputs(ctrl_inputs),
        .ctrl_outputs(ctrl_outputs), .ctrl_ready(ctrl_ready)
    );

    // Design 2 echoes its inputs; the others xor with a per-design constant.
    function automatic logic [NI-1:0] design_fn(input logic [SW-1:0] s, input logic [NI-1:0] x);
        logic [7:0] k;
        k = 8'(8'h11 * (s[7:0] + 8'd1));
        return (s == 9'd2) ? x : (x ^ k);
    endfunction

    // Controller model: START pulse once per round, inputs sampled at START,
    // results of a round appear on outputs at the following START.
    int ph = 0;
    logic hold_low = 1'b0;
    logic [NI-1:0] pending = '0;
    always @(posedge clk) begin
        if (ctrl_ready) begin
            ctrl_outputs <= pending;
            pending      <= design_fn(ctrl_active_select, ctrl_inputs);
        end
        ph         <= (ph == ROUND-1) ? 0 : ph + 1;
        ctrl_ready <= (ph == ROUND-1) && !hold_low;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [NR-1:0] g; logic [NI-1:0] o; logic e; } exp_t;
    exp_t sb[$];
    exp_t mx;

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                mx = sb.pop_front();
                chk("resp_grant", 32'(grant), 32'(mx.g));
                chk("resp_outputs", 32'(resp_outputs), 32'(mx.o));
                chk("resp_error", 32'(resp_error), 32'(mx.e));
            end
        end
    end

    // ctrl_* may only move on an edge that closed a ready=1 cycle.
    logic [SW-1:0] last_sel = '0;
    logic [NI-1:0] last_in = '0;
    logic last_rdy = 1'b0, last_rst = 1'b1;
    always @(negedge clk) begin
        if (!reset && !last_rst && ({ctrl_active_select, ctrl_inputs} !== {last_sel, last_in}))
            chk("ctrl_change_on_ready", 32'(last_rdy), 32'd1);
        last_sel <= ctrl_active_select;
        last_in  <= ctrl_inputs;
        last_rdy <= ctrl_ready;
        last_rst <= reset;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic issue(input int r, input logic [SW-1:0] s, input logic [NI-1:0] d);
        req_select[r*SW +: SW] = s;
        req_inputs[r*NI +: NI] = d;
        req[r] = 1'b1;
    endtask

    task automatic wait_sb(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic mid_round();
        while (ph != ROUND/2) tick();
    endtask

    typedef struct { int r; logic [SW-1:0] sel; logic [NI-1:0] din; logic [NI-1:0] dout; logic err; } vec_t;
    vec_t tv[8];

    initial begin
        int n;
        tv[0] = '{0, 9'd2,   8'hA5, 8'hA5, 1'b0};
        tv[1] = '{1, 9'd7,   8'h3C, 8'h00, 1'b1};
        tv[2] = '{2, 9'd0,   8'h5A, 8'h4B, 1'b0};
        tv[3] = '{3, 9'd3,   8'hF0, 8'hB4, 1'b0};
        tv[4] = '{1, 9'd1,   8'h0F, 8'h2D, 1'b0};
        tv[5] = '{3, 9'd4,   8'hFF, 8'h00, 1'b1};
        tv[6] = '{0, 9'd511, 8'h81, 8'h00, 1'b1};
        tv[7] = '{2, 9'd2,   8'h3C, 8'h3C, 1'b0};

        req = '0; req_select = '0; req_inputs = '0; reset = 1'b1;
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_outputs", 32'(resp_outputs), 32'd0);
        chk("rst_ctrl_sel", 32'(ctrl_active_select), 32'd0);
        chk("rst_ctrl_inputs", 32'(ctrl_inputs), 32'd0);
        reset = 1'b0;
        tick();

        // Single-requester vectors, each issued mid-round while ready is low.
        for (int i = 0; i < 8; i++) begin
            mid_round();
            issue(tv[i].r, tv[i].sel, tv[i].din);
            sb.push_back('{g: NR'(1) << tv[i].r, o: tv[i].dout, e: tv[i].err});
            wait_sb("vec_resp_timeout", 4*ROUND);
            req = '0;
            tick();
            chk("grant_cleared", 32'(grant), 32'd0);
        end

        // Bad select: response exactly two edges after req, ctrl_* untouched.
        mid_round();
        issue(1, 9'd7, 8'h99);
        sb.push_back('{g: 4'b0010, o: 8'h00, e: 1'b1});
        tick();
        chk("badsel_no_early_resp", 32'(resp_valid), 32'd0);
        chk("badsel_grant", 32'(grant), 32'h2);
        tick();
        chk("badsel_resp_at_2", 32'(resp_valid), 32'd1);
        chk("badsel_ctrl_sel_kept", 32'(ctrl_active_select), 32'd2);
        chk("badsel_ctrl_in_kept", 32'(ctrl_inputs), 32'h3C);
        wait_sb("badsel_timeout", 4);
        req = '0;
        tick();

        // Round-robin with all requesters held, starting from a fresh pointer.
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        issue(0, 9'd0, 8'h10); issue(1, 9'd1, 8'h20); issue(2, 9'd2, 8'h30); issue(3, 9'd3, 8'h40);
        sb.push_back('{g: 4'b0001, o: 8'h01, e: 1'b0});
        sb.push_back('{g: 4'b0010, o: 8'h02, e: 1'b0});
        sb.push_back('{g: 4'b0100, o: 8'h30, e: 1'b0});
        sb.push_back('{g: 4'b1000, o: 8'h04, e: 1'b0});
        sb.push_back('{g: 4'b0001, o: 8'h01, e: 1'b0});
        wait_sb("rr_timeout", 20*ROUND);
        req = '0;
        repeat (2*ROUND) tick();

        // Reset during RUN_B: the second START after the grant enters RUN_B.
        mid_round();
        issue(0, 9'd3, 8'h77);
        n = 0;
        for (int t = 0; t < 4*ROUND && n < 2; t++) begin
            tick();
            if (ctrl_ready) n++;
        end
        chk("runb_reached", 32'(n), 32'd2);
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_ctrl_sel", 32'(ctrl_active_select), 32'd0);
        chk("midrst_ctrl_in", 32'(ctrl_inputs), 32'd0);
        req = '0;
        tick(); tick();
        reset = 1'b0;
        repeat (3*ROUND) tick();
        mid_round();
        issue(2, 9'd1, 8'h81);
        sb.push_back('{g: 4'b0100, o: 8'hA3, e: 1'b0});
        wait_sb("post_rst_timeout", 4*ROUND);
        req = '0;
        tick();

`ifdef SCAN_ARB_TIMEOUT_EN
        // Ready held low: the watchdog ends the SWITCH wait.
        hold_low = 1'b1;
        repeat (ROUND + 2) tick();
        issue(3, 9'd0, 8'h55);
        sb.push_back('{g: 4'b1000, o: 8'h00, e: 1'b1});
        wait_sb("watchdog_resp", TO + 3);
        req = '0;
        tick();
        hold_low = 1'b0;
        repeat (2*ROUND) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
